// File: rtl/axi_slave_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_mem_controller_pkg
//  Purpose  : Shared encodings for the AXI-slave-to-RAM controller: write and
//             read FSM state codes, arbiter grant encoding, and a helper that
//             turns the bus data width into a byte-to-word address shift.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axi_slave_mem_controller_pkg;

    // Write burst engine states
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Read burst engine states
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // last_grant encoding and one-hot grant bit positions
    localparam logic GRANT_W   = 1'b0;
    localparam logic GRANT_R   = 1'b1;
    localparam int   GNT_W_BIT = 0;
    localparam int   GNT_R_BIT = 1;

    typedef logic [1:0] grant_t;

    // log2 of bytes per data word; data width is a power of two >= 8
    function automatic int bytes_log2(input int data_width);
        int result;
        result = 0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slave_mem_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_mem_controller_if
//  Purpose  : AXI user-bus channel bundle (AW, W, B, AR, R) between a master
//             and the memory controller slave.
//  Ports    : awvalid/awaddr/awlen/awready, wdata/wlast/wvalid/wready,
//             bvalid/bready, arvalid/araddr/arlen/arready,
//             rdata/rlast/rvalid/rready
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_slave_mem_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  awvalid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awvalid, awaddr, awlen, wdata, wlast, wvalid, bready,
               arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rdata, rlast, rvalid
    );

    modport master (
        output awvalid, awaddr, awlen, wdata, wlast, wvalid, bready,
               arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rdata, rlast, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_slave_mem_controller_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_rr_arbiter
//  Purpose  : Two-requester round-robin arbiter for the single RAM port.
//             Grant is combinational; when both request, the requester that
//             did not win last time gets the port.
//  Ports    : clk_i, rst_n_i (async active-low), req_w_i, req_r_i,
//             gnt_o (one-hot: bit 0 write, bit 1 read)
//  Revision : 1.0 - initial release
// ============================================================================
module axi_mem_rr_arbiter
    import axi_slave_mem_controller_pkg::*;
(
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    input  wire logic req_w_i,
    input  wire logic req_r_i,
    output grant_t    gnt_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_w_i && req_r_i) begin
            if (last_grant_q == GRANT_W) begin
                gnt_o[GNT_R_BIT] = 1'b1;
            end else begin
                gnt_o[GNT_W_BIT] = 1'b1;
            end
        end else if (req_w_i) begin
            gnt_o[GNT_W_BIT] = 1'b1;
        end else if (req_r_i) begin
            gnt_o[GNT_R_BIT] = 1'b1;
        end
    end

    // Only an actual grant moves the round-robin pointer
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_o[GNT_R_BIT]) begin
            last_grant_d = GRANT_R;
        end else if (gnt_o[GNT_W_BIT]) begin
            last_grant_d = GRANT_W;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= GRANT_W;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_slave_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_mem_controller
//  Purpose  : Terminates AXI INCR bursts in a single-port on-chip RAM. An
//             independent write engine (AW/W/B) and read engine (AR/R) share
//             the RAM port through a round-robin arbiter. One outstanding
//             burst per direction.
//  Ports    : ACLK, ARESETN (async active-low)
//             s_axi     - AXI channel bundle (slave modport)
//             mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - RAM port
//             err_wlast - sticky flag, wlast disagreed with the beat count
//  Revision : 1.0 - initial release
// ============================================================================
module axi_slave_mem_controller
    import axi_slave_mem_controller_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH     = 10
) (
    input  wire logic                          ACLK,
    input  wire logic                          ARESETN,
    axi_slave_mem_controller_if.slave          s_axi,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]          mem_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      mem_wdata,
    input  wire logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata,
    output logic                               err_wlast
);

    localparam int ADDR_SHIFT = bytes_log2(C_S_AXI_DATA_WIDTH);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);

    // Write engine state
    logic [1:0]                    wr_state_q, wr_state_d;
    logic [MEM_ADDR_WIDTH-1:0]     wr_addr_q,  wr_addr_d;
    logic [7:0]                    wr_cnt_q,   wr_cnt_d;
    logic                          err_q,      err_d;

    // Read engine state
    logic [0:0]                    rd_state_q, rd_state_d;
    logic [MEM_ADDR_WIDTH-1:0]     rd_addr_q,  rd_addr_d;
    logic [7:0]                    rd_cnt_q,   rd_cnt_d;
    logic                          rd_pend_q,  rd_pend_d;   // RAM read in flight
    logic                          rd_ilast_q, rd_ilast_d;  // in-flight read is the last beat
    logic                          rd_done_q,  rd_done_d;   // all beats issued
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
    logic                          rd_valid_q, rd_valid_d;
    logic                          rd_last_q,  rd_last_d;

    logic   wr_req, rd_req, wr_gnt, rd_gnt, rd_hs;
    grant_t gnt;
    logic   unused_addr_bits;

    // Only the word-address slice of the byte addresses is meaningful
    assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    assign wr_req = (wr_state_q == W_DATA) && s_axi.wvalid;
    // One read in flight at a time, and never overwrite an unaccepted beat
    assign rd_req = (rd_state_q == R_DATA) && !rd_done_q && !rd_pend_q &&
                    (!rd_valid_q || s_axi.rready);

    axi_mem_rr_arbiter u_arbiter (
        .clk_i   (ACLK),
        .rst_n_i (ARESETN),
        .req_w_i (wr_req),
        .req_r_i (rd_req),
        .gnt_o   (gnt)
    );

    assign wr_gnt = gnt[GNT_W_BIT];
    assign rd_gnt = gnt[GNT_R_BIT];
    assign rd_hs  = rd_valid_q && s_axi.rready;

    assign s_axi.awready = (wr_state_q == W_IDLE);
    assign s_axi.wready  = wr_gnt;
    assign s_axi.bvalid  = (wr_state_q == W_RESP);
    assign s_axi.arready = (rd_state_q == R_IDLE);
    assign s_axi.rdata   = rd_data_q;
    assign s_axi.rlast   = rd_last_q;
    assign s_axi.rvalid  = rd_valid_q;

    assign mem_en    = wr_gnt | rd_gnt;
    assign mem_we    = wr_gnt;
    assign mem_addr  = wr_gnt ? wr_addr_q : rd_addr_q;
    assign mem_wdata = s_axi.wdata;
    assign err_wlast = err_q;

    // ------------------------------------------------------------------
    // Write engine: the beat counter alone ends the burst; wlast is only
    // cross-checked against it.
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        case (wr_state_q)
            W_IDLE: begin
                if (s_axi.awvalid) begin
                    wr_addr_d  = s_axi.awaddr[ADDR_SHIFT +: MEM_ADDR_WIDTH];
                    wr_cnt_d   = s_axi.awlen;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_gnt) begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    wr_cnt_d  = wr_cnt_q - 8'd1;
                    if (s_axi.wlast != (wr_cnt_q == 8'd0)) begin
                        err_d = 1'b1;
                    end
                    if (wr_cnt_q == 8'd0) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read engine: issue, then capture RAM data the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rd_pend_d  = rd_pend_q;
        rd_ilast_d = rd_ilast_q;
        rd_done_d  = rd_done_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;

        if (rd_hs) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        case (rd_state_q)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    rd_addr_d  = s_axi.araddr[ADDR_SHIFT +: MEM_ADDR_WIDTH];
                    rd_cnt_d   = s_axi.arlen;
                    rd_done_d  = 1'b0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rd_hs && rd_last_q) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (rd_gnt) begin
            rd_pend_d  = 1'b1;
            rd_addr_d  = rd_addr_q + ADDR_ONE;
            rd_cnt_d   = rd_cnt_q - 8'd1;
            rd_ilast_d = (rd_cnt_q == 8'd0);
            if (rd_cnt_q == 8'd0) begin
                rd_done_d = 1'b1;
            end
        end

        // Issue only happens with the output slot free (or freeing), so the
        // capture never collides with an unaccepted beat.
        if (rd_pend_q) begin
            rd_pend_d  = 1'b0;
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
            rd_last_d  = rd_ilast_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_ilast_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_ilast_q <= rd_ilast_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_axi_slave_mem_controller
//  Purpose  : Directed self-checking bench for axi_slave_mem_controller with a
//             behavioural single-port RAM attached to the memory port.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_mem_controller;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAW = 10;

    logic           ACLK = 1'b0;
    logic           ARESETN = 1'b0;
    logic           mem_en, mem_we, err_wlast;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
    logic [DW-1:0]  tb_mem [0:(1<<MAW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    axi_slave_mem_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_slave_mem_controller #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .MEM_ADDR_WIDTH     (MAW)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .s_axi     (bus.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err_wlast (err_wlast)
    );

    always #5 ACLK = ~ACLK;

    // Behavioural RAM: read data appears the cycle after the request
    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic idle_inputs();
        bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0;
        bus.wdata = '0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.rready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ARESETN = 0;
        repeat (3) tick();
        n_cmp++;
        if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, mem_en, err_wlast} !== 8'b1100_0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 11000000",
                     {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, mem_en, err_wlast});
        end
        n_cmp++;
        if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        @(negedge ACLK);
        ARESETN = 1;
        tick();
    endtask

    task automatic test_write_burst();
        bus.awvalid = 1; bus.awaddr = 32'h10; bus.awlen = 8'd3; #1;
        n_cmp++;
        if (bus.awready !== 1'b1) begin n_bad++; $display("FAIL wr_awready: got %b want 1", bus.awready); end
        tick();
        bus.awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            bus.wvalid = 1; bus.wdata = 32'hA0 + i; bus.wlast = (i == 3); #1;
            n_cmp++;
            if ({mem_en, mem_we, bus.wready} !== 3'b111) begin
                n_bad++; $display("FAIL wr_beat%0d_ctl: got %b want 111", i, {mem_en, mem_we, bus.wready});
            end
            n_cmp++;
            if (mem_addr !== MAW'(4 + i) || mem_wdata !== 32'hA0 + i) begin
                n_bad++; $display("FAIL wr_beat%0d_addr_data: got %0d/%h want %0d/%h", i, mem_addr, mem_wdata, 4 + i, 32'hA0 + i);
            end
            tick();
        end
        bus.wvalid = 0; bus.wlast = 0; #1;
        n_cmp++;
        if ({bus.bvalid, bus.awready} !== 2'b10) begin
            n_bad++; $display("FAIL wr_bvalid: got bvalid/awready %b want 10", {bus.bvalid, bus.awready});
        end
        bus.bready = 1;
        tick();
        bus.bready = 0; #1;
        n_cmp++;
        if ({bus.bvalid, bus.awready, err_wlast} !== 3'b010) begin
            n_bad++; $display("FAIL wr_done: got bvalid/awready/err %b want 010", {bus.bvalid, bus.awready, err_wlast});
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (tb_mem[4 + i] !== 32'hA0 + i) begin
                n_bad++; $display("FAIL wr_ram%0d: got %h want %h", 4 + i, tb_mem[4 + i], 32'hA0 + i);
            end
        end
    endtask

    task automatic test_read_burst();
        int cyc, prev, rb;
        bus.arvalid = 1; bus.araddr = 32'h10; bus.arlen = 8'd3; bus.rready = 1; #1;
        n_cmp++;
        if (bus.arready !== 1'b1) begin n_bad++; $display("FAIL rd_arready: got %b want 1", bus.arready); end
        tick();
        bus.arvalid = 0; #1;
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'd4) begin
            n_bad++; $display("FAIL rd_issue0: got en/we %b addr %0d want 10 addr 4", {mem_en, mem_we}, mem_addr);
        end
        cyc = 0; prev = 0; rb = 0;
        while (rb < 4 && cyc < 30) begin
            if (bus.rvalid === 1'b1) begin
                n_cmp++;
                if (bus.rdata !== 32'hA0 + rb || bus.rlast !== (rb == 3)) begin
                    n_bad++; $display("FAIL rd_beat%0d: got %h last %b want %h last %b", rb, bus.rdata, bus.rlast, 32'hA0 + rb, rb == 3);
                end
                if (rb > 0) begin
                    n_cmp++;
                    if (cyc - prev != 2) begin n_bad++; $display("FAIL rd_rate%0d: got %0d cycles want 2", rb, cyc - prev); end
                end
                prev = cyc;
                rb++;
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (rb != 4 || bus.arready !== 1'b1) begin
            n_bad++; $display("FAIL rd_complete: got beats %0d arready %b want 4 1", rb, bus.arready);
        end
        bus.rready = 0;
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] exp_r [8];
        int wb, rb;
        logic exp_we;
        for (int i = 0; i < 4; i++) exp_r[i] = 32'hA0 + i;
        for (int i = 4; i < 8; i++) exp_r[i] = 32'h1004 + i;
        bus.awvalid = 1; bus.awaddr = 32'h100; bus.awlen = 8'd7;
        bus.arvalid = 1; bus.araddr = 32'h10;  bus.arlen = 8'd7;
        bus.rready = 1; bus.bready = 1; #1;
        n_cmp++;
        if ({bus.awready, bus.arready} !== 2'b11) begin
            n_bad++; $display("FAIL cc_accept: got %b want 11", {bus.awready, bus.arready});
        end
        tick();
        bus.awvalid = 0; bus.arvalid = 0;
        wb = 0; rb = 0;
        for (int c = 1; c <= 24; c++) begin
            bus.wvalid = (wb < 8); bus.wdata = 32'hC0 + wb; bus.wlast = (wb == 7); #1;
            if (c <= 16) begin
                exp_we = (c % 2 == 1);
                n_cmp++;
                if ({mem_en, mem_we} !== {1'b1, exp_we}) begin
                    n_bad++; $display("FAIL cc_grant_c%0d: got en/we %b want 1%b", c, {mem_en, mem_we}, exp_we);
                end
            end
            if (bus.wready === 1'b1) wb++;
            if (bus.rvalid === 1'b1 && rb < 8) begin
                n_cmp++;
                if (bus.rdata !== exp_r[rb] || bus.rlast !== (rb == 7)) begin
                    n_bad++; $display("FAIL cc_rbeat%0d: got %h last %b want %h last %b", rb, bus.rdata, bus.rlast, exp_r[rb], rb == 7);
                end
                rb++;
            end
            tick();
        end
        bus.wvalid = 0; bus.wlast = 0; bus.bready = 0; bus.rready = 0; #1;
        n_cmp++;
        if (wb != 8 || rb != 8) begin n_bad++; $display("FAIL cc_beats: got w %0d r %0d want 8 8", wb, rb); end
        n_cmp++;
        if ({bus.awready, bus.arready, bus.bvalid, err_wlast} !== 4'b1100) begin
            n_bad++; $display("FAIL cc_idle: got %b want 1100", {bus.awready, bus.arready, bus.bvalid, err_wlast});
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (tb_mem[64 + i] !== 32'hC0 + i) begin
                n_bad++; $display("FAIL cc_ram%0d: got %h want %h", 64 + i, tb_mem[64 + i], 32'hC0 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.arvalid = 1; bus.araddr = 32'h100; bus.arlen = 8'd2; bus.rready = 0;
        tick();
        bus.arvalid = 0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 10) begin tick(); n++; end
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hC0) begin
            n_bad++; $display("FAIL bp_beat0: got valid %b data %h want 1 c0", bus.rvalid, bus.rdata);
        end
        bus.rready = 1; #1;
        tick();
        bus.rready = 0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 10) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({bus.rvalid, mem_en} !== 2'b10 || bus.rdata !== 32'hC1 || bus.rlast !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold%0d: got valid/en %b data %h want 10 c1", k, {bus.rvalid, mem_en}, bus.rdata);
            end
            tick();
        end
        bus.rready = 1; #1;
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'd66) begin
            n_bad++; $display("FAIL bp_reissue: got en/we %b addr %0d want 10 addr 66", {mem_en, mem_we}, mem_addr);
        end
        tick();
        bus.rready = 0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 10) begin tick(); n++; end
        n_cmp++;
        if (bus.rdata !== 32'hC2 || bus.rlast !== 1'b1) begin
            n_bad++; $display("FAIL bp_beat2: got %h last %b want c2 last 1", bus.rdata, bus.rlast);
        end
        bus.rready = 1; #1;
        tick();
        bus.rready = 0; #1;
        n_cmp++;
        if ({bus.arready, bus.rvalid} !== 2'b10) begin
            n_bad++; $display("FAIL bp_idle: got arready/rvalid %b want 10", {bus.arready, bus.rvalid});
        end
    endtask

    task automatic test_wrap_err();
        bus.awvalid = 1; bus.awaddr = 32'hFFC; bus.awlen = 8'd1;
        tick();
        bus.awvalid = 0;
        bus.wvalid = 1; bus.wdata = 32'hD0; bus.wlast = 1; #1;
        n_cmp++;
        if (bus.wready !== 1'b1 || mem_addr !== 10'd1023) begin
            n_bad++; $display("FAIL wrap_beat0: got wready %b addr %0d want 1 1023", bus.wready, mem_addr);
        end
        tick();
        n_cmp++;
        if (err_wlast !== 1'b1) begin n_bad++; $display("FAIL wrap_err: got %b want 1", err_wlast); end
        bus.wdata = 32'hD1; bus.wlast = 1; #1;
        n_cmp++;
        if (bus.wready !== 1'b1 || mem_addr !== 10'd0) begin
            n_bad++; $display("FAIL wrap_beat1: got wready %b addr %0d want 1 0", bus.wready, mem_addr);
        end
        tick();
        bus.wvalid = 0; bus.wlast = 0; bus.bready = 1; #1;
        n_cmp++;
        if (bus.bvalid !== 1'b1) begin n_bad++; $display("FAIL wrap_bvalid: got %b want 1", bus.bvalid); end
        tick();
        bus.bready = 0;
        n_cmp++;
        if (tb_mem[1023] !== 32'hD0 || tb_mem[0] !== 32'hD1 || err_wlast !== 1'b1) begin
            n_bad++; $display("FAIL wrap_ram: got %h %h err %b want d0 d1 err 1", tb_mem[1023], tb_mem[0], err_wlast);
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        bus.arvalid = 1; bus.araddr = 32'h10; bus.arlen = 8'd7; bus.rready = 1;
        tick();
        bus.arvalid = 0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 10) begin tick(); n++; end
        @(negedge ACLK);
        ARESETN = 0; #1;
        n_cmp++;
        if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, mem_en, err_wlast} !== 8'b1100_0000 || bus.rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid: got %b rdata %h want 11000000 rdata 0",
                     {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, mem_en, err_wlast}, bus.rdata);
        end
        @(negedge ACLK);
        ARESETN = 1;
        tick();
        bus.arvalid = 1; bus.araddr = 32'h100; bus.arlen = 8'd0;
        tick();
        bus.arvalid = 0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 10) begin tick(); n++; end
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hC0 || bus.rlast !== 1'b1) begin
            n_bad++; $display("FAIL rst_after: got valid %b data %h last %b want 1 c0 1", bus.rvalid, bus.rdata, bus.rlast);
        end
        tick();
        bus.rready = 0; #1;
        n_cmp++;
        if ({bus.arready, bus.rvalid} !== 2'b10) begin
            n_bad++; $display("FAIL rst_after_idle: got %b want 10", {bus.arready, bus.rvalid});
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << MAW); i++) tb_mem[i] = 32'h1000 + i;
        mem_rdata = '0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_concurrent();
        test_backpressure();
        test_wrap_err();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
